// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment bus type, bit positions and hex glyph patterns (abcdefg, dp excluded).
package seven_seg_pkg;
  typedef logic [7:0] seg_t;
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_H = 0;
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;
endpackage

// File: rtl/seven_seg_glyph_decoder.sv
// seven_seg_glyph_decoder: maps a segment pattern back to its hex nibble; known=0 for any other pattern.
module seven_seg_glyph_decoder
  import seven_seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       known
);
  assign dp = seg[SEG_H];
  always_comb begin
    nibble = 4'h0;
    known  = 1'b1;
    case (seg[SEG_A:SEG_G])
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: known = 1'b0;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: samples a scanned 7-seg bus, rejects ghosting and rebuilds hex frames.
// Define SEVEN_SEG_ERR_COUNT_EN to add a saturating err_count output.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int w_digit        = 8,
  parameter int stable_cycles  = 4,
  parameter int timeout_cycles = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  seg_t                 abcdefgh,
  input  logic [w_digit-1:0]   digit,
  output logic [4*w_digit-1:0] value,
  output logic [w_digit-1:0]   dp,
  output logic                 frame_valid,
  output logic                 decode_err,
  output logic                 stale
`ifdef SEVEN_SEG_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);
  localparam int SW = $clog2(stable_cycles + 1);
  localparam int TW = $clog2(timeout_cycles + 1);
  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;
  state_t               state, state_nx;
  seg_t                 seg_s;
  logic [w_digit-1:0]   dig_s, seen, cap_dp;
  logic [4*w_digit-1:0] cap_val;
  logic [SW-1:0]        cnt;
  logic [TW-1:0]        idle_cnt;
  logic [3:0]           nibble;
  logic                 seg_dp, known, capture, multi, store, full;
  seven_seg_glyph_decoder u_dec (.seg(seg_s), .nibble, .dp(seg_dp), .known);
  assign multi = (dig_s & (dig_s - w_digit'(1))) != '0;
  assign store = capture && !multi && known;
  assign full  = &seen;
  assign stale = idle_cnt == TW'(timeout_cycles);
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      IDLE: state_nx = dig_s != '0 ? WAIT : IDLE;
      WAIT: begin
        capture  = dig_s != '0 && cnt == SW'(stable_cycles);
        state_nx = dig_s == '0 ? IDLE : capture ? HELD : WAIT;
      end
      HELD: state_nx = cnt != '0 ? HELD : dig_s == '0 ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      seg_s       <= '0;
      dig_s       <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
      seen        <= '0;
      cap_val     <= '0;
      cap_dp      <= '0;
      value       <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      seg_s       <= abcdefgh;
      dig_s       <= digit;
      cnt         <= (abcdefgh != seg_s || digit != dig_s) ? '0 :
                     cnt == SW'(stable_cycles) ? cnt : cnt + SW'(1);
      idle_cnt    <= store ? '0 : stale ? idle_cnt : idle_cnt + TW'(1);
      decode_err  <= capture && !store;
      frame_valid <= full;
      if (full) begin
        value <= cap_val;
        dp    <= cap_dp;
        seen  <= '0;
      end else if (capture && multi) begin
        seen <= '0;
      end else if (store) begin
        seen <= seen | dig_s;
      end
      for (int i = 0; i < w_digit; i++) begin
        if (store && dig_s[i]) begin
          cap_val[4*i +: 4] <= nibble;
          cap_dp[i]         <= seg_dp;
        end
      end
    end
  end
`ifdef SEVEN_SEG_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_count <= '0;
    else if (capture && !store && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: randomized scoreboard bench; expected frames/errors come from a segment-level model.
module tb_seven_seg_scan_decoder;
  localparam int W = 8, STABLE = 4, TIMEOUT = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0]     abcdefgh = '0;
  logic [W-1:0]   digit = '0;
  logic [4*W-1:0] value;
  logic [W-1:0]   dp;
  logic           frame_valid, decode_err, stale;
`ifdef SEVEN_SEG_ERR_COUNT_EN
  logic [7:0]     err_count;
`endif
  seven_seg_scan_decoder #(.w_digit(W), .stable_cycles(STABLE), .timeout_cycles(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .abcdefgh(abcdefgh), .digit(digit), .value(value), .dp(dp),
    .frame_valid(frame_valid), .decode_err(decode_err), .stale(stale)
`ifdef SEVEN_SEG_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {bit is_frame; logic [4*W-1:0] v; logic [W-1:0] d;} ev_t;
  ev_t q[$];
  ev_t mon_e;
  int checks = 0, errors = 0;
  logic [6:0] table_g [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [4*W-1:0] m_val;
  logic [W-1:0]   m_dp, m_seen, last_dig;
  logic [7:0]     last_seg;
  int             run_len, m_errs;
  bit             run_cap;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_ev(bit is_frame);
    ev_t e;
    e.is_frame = is_frame;
    e.v = m_val;
    e.d = m_dp;
    q.push_back(e);
  endtask
  task automatic model_capture(logic [W-1:0] d, logic [7:0] s);
    int nib = -1, idx = 0;
    for (int i = 0; i < 16; i++) if (table_g[i] == s[7:1]) nib = i;
    for (int i = 0; i < W; i++) if (d[i]) idx = i;
    if ($countones(d) > 1) begin
      m_errs++;
      m_seen = '0;
      push_ev(1'b0);
    end else if (nib < 0) begin
      m_errs++;
      push_ev(1'b0);
    end else begin
      m_val[4*idx +: 4] = 4'(nib);
      m_dp[idx] = s[0];
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
        push_ev(1'b1);
        m_seen = '0;
      end
    end
  endtask
  // A hold identical to the previous one just extends the same stable run.
  task automatic hold(logic [W-1:0] d, logic [7:0] s, int n);
    if (d == last_dig && s == last_seg) run_len += n;
    else begin
      run_len = n;
      run_cap = 1'b0;
      last_dig = d;
      last_seg = s;
    end
    if (!run_cap && d != '0 && run_len >= STABLE + 1) begin
      run_cap = 1'b1;
      model_capture(d, s);
    end
    digit = d;
    abcdefgh = s;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put(int i, int nib, bit dpb, int n);
    hold(W'(1) << i, {table_g[nib], dpb}, n);
  endtask
  function automatic logic [W-1:0] rand_dig();
    int r = $urandom_range(0, 29);
    int a = $urandom_range(0, W - 1);
    int b = (a + 1 + $urandom_range(0, W - 2)) % W;
    if (r == 0) return '0;
    if (r == 1) return (W'(1) << a) | (W'(1) << b);
    return W'(1) << a;
  endfunction
  function automatic logic [7:0] rand_seg();
    if ($urandom_range(0, 15) == 0) return 8'($urandom);
    return {table_g[$urandom_range(0, 15)], 1'($urandom)};
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    abcdefgh = 8'($urandom);
    digit = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    abcdefgh = '0;
    digit = '0;
    q.delete();
    m_val = '0;
    m_dp = '0;
    m_seen = '0;
    last_dig = '0;
    last_seg = '0;
    run_len = 0;
    run_cap = 1'b0;
    m_errs = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n && (frame_valid || decode_err)) begin
      if (q.size() == 0) check("unexpected_event", {frame_valid, decode_err}, 2'b00);
      else begin
        mon_e = q.pop_front();
        check("event_kind", {frame_valid, decode_err}, mon_e.is_frame ? 2'b10 : 2'b01);
        if (mon_e.is_frame) begin
          check("frame_value", value, mon_e.v);
          check("frame_dp", dp, mon_e.d);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_value", value, 0);
    check("rst_dp", dp, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_decode_err", decode_err, 0);
    check("rst_stale", stale, 0);
`ifdef SEVEN_SEG_ERR_COUNT_EN
    check("rst_err_count", err_count, 0);
`endif
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      check("stale_idle", stale, k >= TIMEOUT);
    end
    put(0, 7, 0, 5);
    check("stale_before_capture", stale, 1);
    put(0, 7, 0, 1);
    check("stale_cleared", stale, 0);
    put(0, 3, 0, 6);
    put(1, 1, 0, 6);
    put(2, 4, 1, 6);
    put(3, 1, 0, 6);
    put(4, 5, 0, 6);
    put(5, 9, 0, 6);
    put(6, 2, 0, 6);
    put(7, 6, 0, 6);
    check("fv_not_yet", frame_valid, 0);
    @(posedge clk);
    #1;
    check("fv_pulse", frame_valid, 1);
    check("pi_value", value, 32'h62951413);
    @(posedge clk);
    #1;
    check("fv_one_cycle", frame_valid, 0);
    hold(W'(1), 8'hFE, 3);
    hold(W'(1), 8'hFC, 6);
    for (int i = 1; i < W; i++) put(i, i, 0, 6);
    repeat (2) @(posedge clk);
    #1;
    check("ghost_nibble0", value[3:0], 0);
    put(0, 1, 0, 6);
    put(1, 2, 0, 6);
    hold(8'b0000_0011, {table_g[5], 1'b0}, 6);
    for (int i = 0; i < W; i++) put(i, 15 - i, 0, 6);
    for (int i = 0; i < 4; i++) put(i, 10, 0, 6);
    hold(8'b0000_1000, 8'b1000_0000, 6);
    for (int i = 4; i < W; i++) put(i, 11, 1, 6);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 2) == 0) hold(rand_dig(), 8'($urandom), $urandom_range(1, 4));
        put(i, $urandom_range(0, 15), 1'($urandom), $urandom_range(5, 7));
      end
    end
    for (int r = 0; r < 150; r++) hold(rand_dig(), rand_seg(), $urandom_range(1, 8));
`ifdef SEVEN_SEG_ERR_COUNT_EN
    for (int r = 0; r < 150; r++) begin
      hold(8'b0000_0011, {table_g[1], 1'b0}, 5);
      hold(8'b0000_0110, {table_g[2], 1'b0}, 5);
    end
`endif
    hold('0, '0, 2);
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
`ifdef SEVEN_SEG_ERR_COUNT_EN
    check("err_count", err_count, m_errs > 255 ? 255 : m_errs);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
